mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Sequencing controller for the CPU's memory-mapped I/O region (addr[31:28] = 4'b1000).
- Owns the UART transmit holding register and the receive buffer FIFO, the cycle and instruction-retire counters, and button-FIFO pop strobes.
- Its status and data outputs are the sources that the data-memory read-select mux presents to loads in that region.
- Sits between the pipeline's memory stage and the UART, button FIFO and counters.

Parameters:
- MMIO_TAG, 4'b1000: value of addr[31:28] that selects the I/O region.
- RX_DEPTH, 4: receive FIFO entries; power of two, at least 2.
- CNT_WIDTH, 32: counter width; fixed at 32 because the counters are read as full words.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- addr  in  32  memory-stage byte address
- wdata  in  32  store data
- mem_we  in  1  store strobe, any byte enable
- mem_re  in  1  load strobe
- stall  in  1  pipeline stall; when 1, mem_we and mem_re are ignored
- inst_retire  in  1  one instruction retired this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts rx_data
- trmt_full  out  1  transmit holding register occupied
- recv_empty  out  1  receive FIFO empty
- recv_data  out  8  receive FIFO head byte
- counter_cycle  out  32  cycle counter
- counter_inst  out  32  retired-instruction counter
- buttons_empty  in  1  button FIFO empty
- buttons_rd_en  out  1  button FIFO pop strobe

Behaviour:
- Region hit: hit = (addr[31:28] == MMIO_TAG) & ~stall.
  - Register offsets are decoded from addr[5:2]. addr[1:0] is ignored.
  - Offset 0x08 is tx data (W). Offset 0x04 is rx data (R).
  - Offsets 0x10/0x14 are the cycle/inst counters (R). Offset 0x18 is counter reset (W).
  - Offset 0x24 is button data (R).
- Reset values: tx_valid = 0, tx_data = 0, trmt_full = 0, recv_empty = 1, recv_data = 0, rx_ready = 1, counter_cycle = 0, counter_inst = 0, buttons_rd_en = 0. The FIFO pointers are cleared.
- Reset mid-operation: an in-flight tx byte and all buffered rx bytes are discarded immediately and asynchronously.
- TX state machine, two states:
  - TX_IDLE: tx_valid = 0. A store hit at 0x08 loads tx_data = wdata[7:0] and moves to TX_BUSY on the next edge.
  - TX_BUSY: tx_valid = 1. When tx_valid & tx_ready, return to TX_IDLE.
  - A store to 0x08 in TX_BUSY is dropped, including the cycle in which the handshake completes. Software must poll trmt_full.
  - trmt_full = (state == TX_BUSY). It is registered, with no combinational path from tx_ready.
- RX FIFO:
  - Depth RX_DEPTH, with read and write pointers one bit wider than the index.
  - rx_ready = ~full | pop. Push = rx_valid & rx_ready.
  - Pop = load hit at 0x04 & ~recv_empty. A load at 0x04 while empty does not pop; the loaded value is don't-care.
  - recv_data is the combinational head entry and is stable until the pop edge. The load samples it in the same cycle as the pop.
  - Simultaneous push and pop: both occur and the count is unchanged. When full, simultaneous pop and push is accepted.
  - recv_empty and full are derived from the pointers.
- Counters:
  - counter_cycle increments by 1 every cycle.
  - counter_inst increments by 1 when inst_retire = 1.
  - Both wrap from 0xFFFFFFFF to 0.
  - A store hit at 0x18, with any data, sets both counters to 0 on the next edge. Reset has priority over increment in that cycle.
  - The counters then resume counting from 0 on the following cycle.
- Buttons: buttons_rd_en = load hit at 0x24 & ~buttons_empty. It is combinational, exactly one cycle per load.
- mem_we and mem_re asserted together at the same address: the store action and the load action both apply.
- stall = 1 suppresses every pop, push-from-store and counter-reset action. Free-running counting continues under stall.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs reach their reset values before the next edge; recv_empty = 1, counters = 0.
- TX: store 0x41 to 0x80000008 with tx_ready held 0 for 3 cycles -> tx_valid = 1 and tx_data = 0x41 for 4 cycles. A second store of 0x42 during busy is dropped. After tx_ready = 1, trmt_full = 0 next cycle.
- RX: push 0x11, 0x22, 0x33, 0x44 with no loads -> full, rx_ready = 0 while rx_valid is held with 0x55. One load of 0x80000004 returns 0x11 and 0x55 is accepted that cycle. The next four loads return 0x22, 0x33, 0x44, 0x55, then recv_empty = 1.
- Counters: preload via 2^32-2 cycles (or force) -> wrap from 0xFFFFFFFF to 0. Store to 0x80000018 while inst_retire = 1 -> both counters 0 next cycle and 1/1 the cycle after.
- Buttons: load 0x80000024 with buttons_empty = 0 -> single buttons_rd_en pulse. With buttons_empty = 1, or with stall = 1 -> no pulse.
- Address gating: store to 0x10000008 -> no tx_valid. Load of 0x00000004 -> no rx pop.

Source files
------------

// File: rtl/mmio_ctrl.sv
// MMIO sequencing controller: UART transmit holding register, receive FIFO,
// cycle/retire counters and button-FIFO pop strobe for the I/O address region.
module mmio_ctrl #(
    parameter logic [3:0]  MMIO_TAG  = 4'b1000,
    parameter int unsigned RX_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 mem_we,
    input  logic                 mem_re,
    input  logic                 stall,
    input  logic                 inst_retire,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 trmt_full,
    output logic                 recv_empty,
    output logic [7:0]           recv_data,
    output logic [CNT_WIDTH-1:0] counter_cycle,
    output logic [CNT_WIDTH-1:0] counter_inst,
    input  logic                 buttons_empty,
    output logic                 buttons_rd_en
);

    localparam int unsigned AW = $clog2(RX_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {StTxIdle, StTxBusy} tx_state_t;

    // Address decode; offsets come from the word index addr[5:2]
    logic       hit;
    logic [3:0] off;
    logic       tx_store;
    logic       rx_load;
    logic       cnt_clear;

    assign hit       = (addr[31:28] == MMIO_TAG) && !stall;
    assign off       = addr[5:2];
    assign tx_store  = hit && mem_we && (off == 4'h2);
    assign rx_load   = hit && mem_re && (off == 4'h1);
    assign cnt_clear = hit && mem_we && (off == 4'h6);

    assign buttons_rd_en = hit && mem_re && (off == 4'h9) && !buttons_empty;

    logic unused_bits;
    assign unused_bits = ^{addr[27:6], addr[1:0], wdata[31:8]};

    // ---------------- TX holding register ----------------
    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= StTxIdle;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            StTxIdle: if (tx_store) tx_state_d = StTxBusy;
            StTxBusy: if (tx_ready) tx_state_d = StTxIdle;
            default:  tx_state_d = StTxIdle;
        endcase
    end

    always_comb begin
        tx_valid  = (tx_state_q == StTxBusy);
        trmt_full = (tx_state_q == StTxBusy);
    end

    // Stores while busy, including the handshake cycle, are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q <= 8'h00;
        end else if ((tx_state_q == StTxIdle) && tx_store) begin
            tx_data_q <= wdata[7:0];
        end
    end

    assign tx_data = tx_data_q;

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [RX_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        rx_full;
    logic        rx_push;
    logic        rx_pop;

    assign rx_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign recv_empty = (wr_ptr_q == rd_ptr_q);
    assign rx_pop     = rx_load && !recv_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    assign rx_ready   = !rx_full || rx_pop;
    assign rx_push    = rx_valid && rx_ready;
    assign recv_data  = rx_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < RX_DEPTH; i++) begin
                rx_mem[i] <= 8'h00;
            end
        end else begin
            if (rx_push) begin
                rx_mem[wr_ptr_q[AW-1:0]] <= rx_data;
                wr_ptr_q                 <= wr_ptr_q + PTR_ONE;
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // ---------------- Counters ----------------
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else if (cnt_clear) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_ONE;
            if (inst_retire) begin
                inst_q <= inst_q + CNT_ONE;
            end
        end
    end

    assign counter_cycle = cycle_q;
    assign counter_inst  = inst_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: directed scenarios plus randomized traffic
// compared against a queue/integer reference model.
module tb_mmio_ctrl;

    localparam int unsigned RX_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic        stall = 1'b0;
    logic        inst_retire = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        trmt_full;
    logic        recv_empty;
    logic [7:0]  recv_data;
    logic [31:0] counter_cycle;
    logic [31:0] counter_inst;
    logic        buttons_empty = 1'b1;
    logic        buttons_rd_en;

    int tests = 0;
    int fails = 0;

    mmio_ctrl #(
        .MMIO_TAG (4'b1000),
        .RX_DEPTH (RX_DEPTH),
        .CNT_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .stall        (stall),
        .inst_retire  (inst_retire),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .trmt_full    (trmt_full),
        .recv_empty   (recv_empty),
        .recv_data    (recv_data),
        .counter_cycle(counter_cycle),
        .counter_inst (counter_inst),
        .buttons_empty(buttons_empty),
        .buttons_rd_en(buttons_rd_en)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_rxq[$];
    logic        m_busy;
    logic [7:0]  m_tx_byte;
    logic [31:0] m_cycle;
    logic [31:0] m_inst;

    function automatic logic m_hit();
        return (addr[31:28] == 4'h8) && !stall;
    endfunction

    function automatic logic m_pop();
        return m_hit() && mem_re && (addr[5:2] == 4'h1) && (m_rxq.size() != 0);
    endfunction

    function automatic logic m_btn();
        return m_hit() && mem_re && (addr[5:2] == 4'h9) && !buttons_empty;
    endfunction

    task automatic model_reset();
        m_rxq.delete();
        m_busy    = 1'b0;
        m_tx_byte = 8'h00;
        m_cycle   = 0;
        m_inst    = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic tick();
        logic pop, accept, we_hit;
        if (rst) begin
            model_reset();
        end else begin
            we_hit = m_hit() && mem_we;
            pop    = m_pop();
            accept = rx_valid && ((m_rxq.size() < RX_DEPTH) || pop);
            if (m_busy) begin
                if (tx_ready) m_busy = 1'b0;
            end else if (we_hit && addr[5:2] == 4'h2) begin
                m_busy    = 1'b1;
                m_tx_byte = wdata[7:0];
            end
            if (pop) void'(m_rxq.pop_front());
            if (accept) m_rxq.push_back(rx_data);
            if (we_hit && addr[5:2] == 4'h6) begin
                m_cycle = 0;
                m_inst  = 0;
            end else begin
                m_cycle = m_cycle + 1;
                if (inst_retire) m_inst = m_inst + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        addr = '0; wdata = '0; mem_we = 0; mem_re = 0; stall = 0;
        inst_retire = 0; tx_ready = 0; rx_valid = 0; rx_data = '0; buttons_empty = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] zero32 = 32'h0;
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        tests++; if (recv_empty !== 1'b1) begin fails++; $display("FAIL reset_recv_empty got %b want 1", recv_empty); end
        tests++; if (counter_cycle !== zero32) begin fails++; $display("FAIL reset_cycle got %h want 0", counter_cycle); end
        // build up state, then assert reset between edges
        addr = 32'h8000_0008; wdata = 32'h5A; mem_we = 1; rx_valid = 1; rx_data = 8'hA5;
        tick();
        mem_we = 0;
        tick();
        rx_valid = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL async_tx_valid got %b want 0", tx_valid); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL async_tx_data got %h want 00", tx_data); end
        tests++; if (trmt_full !== 1'b0) begin fails++; $display("FAIL async_trmt_full got %b want 0", trmt_full); end
        tests++; if (recv_empty !== 1'b1) begin fails++; $display("FAIL async_recv_empty got %b want 1", recv_empty); end
        tests++; if (recv_data !== 8'h00) begin fails++; $display("FAIL async_recv_data got %h want 00", recv_data); end
        tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL async_rx_ready got %b want 1", rx_ready); end
        tests++; if (counter_cycle !== zero32 || counter_inst !== zero32) begin
            fails++; $display("FAIL async_counters got %h/%h want 0/0", counter_cycle, counter_inst);
        end
        tests++; if (buttons_rd_en !== 1'b0) begin fails++; $display("FAIL async_btn got %b want 0", buttons_rd_en); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_tx();
        idle_inputs();
        addr = 32'h8000_0008; wdata = 32'hFFFF_FF41; mem_we = 1;
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_idle_valid got %b want 0", tx_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            tx_ready = (i == 3);
            mem_we   = (i == 1) || (i == 3);
            wdata    = (i == 1) ? 32'h42 : 32'h43;
            #1;
            tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
                fails++; $display("FAIL tx_busy[%0d] got %b/%h want 1/41", i, tx_valid, tx_data);
            end
            tick();
        end
        idle_inputs();
        #1;
        tests++; if (trmt_full !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h41) begin
            fails++; $display("FAIL tx_done got %b/%b/%h want 0/0/41", trmt_full, tx_valid, tx_data);
        end
    endtask

    task automatic test_rx();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] pops  [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1; rx_data = bytes[i];
            #1;
            tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_fill[%0d] got %b want 1", i, rx_ready); end
            tick();
        end
        rx_data = 8'h55;
        #1;
        tests++; if (rx_ready !== 1'b0 || recv_data !== 8'h11) begin
            fails++; $display("FAIL rx_full got %b/%h want 0/11", rx_ready, recv_data);
        end
        tick();
        addr = 32'h8000_0004; mem_re = 1;
        #1;
        tests++; if (rx_ready !== 1'b1 || recv_data !== 8'h11) begin
            fails++; $display("FAIL rx_pop_push got %b/%h want 1/11", rx_ready, recv_data);
        end
        tick();
        rx_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (recv_empty !== 1'b0 || recv_data !== pops[i]) begin
                fails++; $display("FAIL rx_drain[%0d] got %b/%h want 0/%h", i, recv_empty, recv_data, pops[i]);
            end
            tick();
        end
        #1;
        tests++; if (recv_empty !== 1'b1) begin fails++; $display("FAIL rx_empty got %b want 1", recv_empty); end
        tick();
        idle_inputs();
    endtask

    task automatic test_counters();
        idle_inputs();
        #1;
        tests++; if (counter_cycle !== m_cycle || counter_inst !== m_inst) begin
            fails++; $display("FAIL cnt_track got %h/%h want %h/%h", counter_cycle, counter_inst, m_cycle, m_inst);
        end
        force dut.cycle_q = 32'hFFFF_FFFF;
        force dut.inst_q  = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        release dut.inst_q;
        m_cycle = 32'hFFFF_FFFF; m_inst = 32'hFFFF_FFFF;
        inst_retire = 1;
        tick();
        #1;
        tests++; if (counter_cycle !== 32'h0 || counter_inst !== 32'h0) begin
            fails++; $display("FAIL cnt_wrap got %h/%h want 0/0", counter_cycle, counter_inst);
        end
        repeat (3) tick();
        addr = 32'h8000_0018; wdata = 32'hDEAD_BEEF; mem_we = 1;
        tick();
        mem_we = 0;
        #1;
        tests++; if (counter_cycle !== 32'h0 || counter_inst !== 32'h0) begin
            fails++; $display("FAIL cnt_clear got %h/%h want 0/0", counter_cycle, counter_inst);
        end
        tick();
        #1;
        tests++; if (counter_cycle !== 32'h1 || counter_inst !== 32'h1) begin
            fails++; $display("FAIL cnt_resume got %h/%h want 1/1", counter_cycle, counter_inst);
        end
        stall = 1; mem_we = 1;
        tick();
        #1;
        tests++; if (counter_cycle !== 32'h2 || counter_inst !== 32'h2) begin
            fails++; $display("FAIL cnt_stall_clear got %h/%h want 2/2", counter_cycle, counter_inst);
        end
        idle_inputs();
    endtask

    task automatic test_buttons();
        idle_inputs();
        addr = 32'h8000_0024; mem_re = 1; buttons_empty = 0;
        #1;
        tests++; if (buttons_rd_en !== 1'b1) begin fails++; $display("FAIL btn_pulse got %b want 1", buttons_rd_en); end
        tick();
        mem_re = 0;
        #1;
        tests++; if (buttons_rd_en !== 1'b0) begin fails++; $display("FAIL btn_single got %b want 0", buttons_rd_en); end
        mem_re = 1; buttons_empty = 1;
        #1;
        tests++; if (buttons_rd_en !== 1'b0) begin fails++; $display("FAIL btn_empty got %b want 0", buttons_rd_en); end
        buttons_empty = 0; stall = 1;
        #1;
        tests++; if (buttons_rd_en !== 1'b0) begin fails++; $display("FAIL btn_stall got %b want 0", buttons_rd_en); end
        tick();
        idle_inputs();
    endtask

    task automatic test_gating();
        idle_inputs();
        addr = 32'h1000_0008; wdata = 32'h77; mem_we = 1;
        tick();
        mem_we = 0;
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL gate_tx got %b want 0", tx_valid); end
        rx_valid = 1; rx_data = 8'h99;
        tick();
        rx_valid = 0; addr = 32'h0000_0004; mem_re = 1;
        tick();
        mem_re = 0;
        #1;
        tests++; if (recv_empty !== 1'b0 || recv_data !== 8'h99) begin
            fails++; $display("FAIL gate_rx got %b/%h want 0/99", recv_empty, recv_data);
        end
        addr = 32'h8000_0004; mem_re = 1;
        tick();
        idle_inputs();
        #1;
        tests++; if (recv_empty !== 1'b1) begin fails++; $display("FAIL gate_rx_pop got %b want 1", recv_empty); end
    endtask

    task automatic test_random();
        logic [31:0] offs [6] = '{32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h24};
        int          sel;
        logic        exp_ready;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 6);
            if (sel < 6) addr = 32'h8000_0000 | offs[sel];
            else         addr = {1'b0, 3'($urandom_range(0, 7)), 28'h000_0004};
            addr[1:0]    = 2'($urandom);
            addr[27:6]   = ($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'h0;
            wdata        = $urandom;
            mem_we       = ($urandom_range(0, 3) == 0);
            mem_re       = ($urandom_range(0, 1) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            inst_retire  = ($urandom_range(0, 1) == 0);
            tx_ready     = ($urandom_range(0, 2) == 0);
            rx_valid     = ($urandom_range(0, 1) == 0);
            rx_data      = 8'($urandom);
            buttons_empty = ($urandom_range(0, 1) == 0);
            #1;
            exp_ready = (m_rxq.size() < RX_DEPTH) || m_pop();
            tests++; if (tx_valid !== m_busy || trmt_full !== m_busy || tx_data !== m_tx_byte) begin
                fails++; $display("FAIL rnd_tx[%0d] got %b/%b/%h want %b/%b/%h", n, tx_valid, trmt_full,
                                  tx_data, m_busy, m_busy, m_tx_byte);
            end
            tests++; if (rx_ready !== exp_ready || recv_empty !== (m_rxq.size() == 0)) begin
                fails++; $display("FAIL rnd_rx_flags[%0d] got %b/%b want %b/%b", n, rx_ready, recv_empty,
                                  exp_ready, (m_rxq.size() == 0));
            end
            if (m_rxq.size() != 0) begin
                tests++; if (recv_data !== m_rxq[0]) begin
                    fails++; $display("FAIL rnd_rx_data[%0d] got %h want %h", n, recv_data, m_rxq[0]);
                end
            end
            tests++; if (counter_cycle !== m_cycle || counter_inst !== m_inst) begin
                fails++; $display("FAIL rnd_cnt[%0d] got %h/%h want %h/%h", n, counter_cycle, counter_inst,
                                  m_cycle, m_inst);
            end
            tests++; if (buttons_rd_en !== m_btn()) begin
                fails++; $display("FAIL rnd_btn[%0d] got %b want %b", n, buttons_rd_en, m_btn());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        test_reset();
        test_tx();
        test_rx();
        test_counters();
        test_buttons();
        test_gating();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
